i2s_transmitter: RTL and testbench

- Serialises stereo parallel samples into an I2S-style left-justified bit stream (sck_clk, ws, sd) that feeds the downstream i2s receiver.
- Runs on one system clock and derives the serial clock by integer division.
- Accepts one stereo frame per valid/ready handshake.
- Double-buffers frames: one shifting, one pending; emits zeros and flags underrun when no frame is available.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_sck_divider.sv | 40 ++++
 rtl/i2s_transmitter.sv | 119 +++++++++++
 tb/tb_i2s_transmitter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmitter: FSM states, default slot width and
// the stereo frame layout (left in the upper half, transmitted first).
package i2s_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DEFAULT_SAMPLE_WIDTH-1:0] left;
        logic [DEFAULT_SAMPLE_WIDTH-1:0] right;
    } frame_t;

endpackage

// File: rtl/i2s_sck_divider.sv
// Serial bit clock generator: toggles sck_clk every SCK_DIV sys_clk cycles
// while run is high and parks it low otherwise.
module i2s_sck_divider #(
    parameter int SCK_DIV = 4
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic run,
    output logic sck_clk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    // Strobes flag the cycle whose closing edge toggles sck, so a consumer can
    // update its own registers on exactly that edge.
    assign wrap     = run && (div_cnt == CW'(SCK_DIV - 1));
    assign rise_stb = wrap && !sck_clk;
    assign fall_stb = wrap && sck_clk;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sck_clk <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            sck_clk <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sck_clk <= !sck_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Left-justified I2S transmitter with a one-frame pending buffer in front of
// the shifter; missing frames are sent as zeros and flagged as underrun.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int SCK_DIV      = 4
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    sck_clk,
    output logic                    ws,
    output logic                    sd,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int FW = 2 * SAMPLE_WIDTH;
    localparam int BW = $clog2(FW);

    state_t        state, state_next;
    logic          load, frame_end, transfer, run;
    logic          fall_stb, rise_unused;
    logic [FW-1:0] pending, shifter;
    logic          pending_full;
    logic [BW-1:0] bit_cnt;

    assign run       = (state != IDLE);
    assign transfer  = in_valid && in_ready;
    assign frame_end = fall_stb && (bit_cnt == BW'(FW - 1));

    // Only the falling edge matters here; the receiver samples on the rise.
    i2s_sck_divider #(.SCK_DIV(SCK_DIV)) u_div (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .run     (run),
        .sck_clk (sck_clk),
        .rise_stb(rise_unused),
        .fall_stb(fall_stb)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN, DRAIN: begin
                if (frame_end) begin
                    load       = enable;
                    state_next = enable ? RUN : IDLE;
                end else begin
                    state_next = enable ? RUN : DRAIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A load in the same cycle as a handshake uses the old pending contents;
    // the new frame lands in pending for the following load.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            pending_full <= 1'b0;
            in_ready     <= 1'b1;
            shifter      <= '0;
            bit_cnt      <= '0;
            ws           <= 1'b1;
            sd           <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load && !pending_full;

            if (transfer) begin
                pending      <= {left_in, right_in};
                pending_full <= 1'b1;
                in_ready     <= 1'b0;
            end else if (load && pending_full) begin
                pending_full <= 1'b0;
                in_ready     <= 1'b1;
            end

            // Left MSB goes out together with the ws drop; no I2S one-bit delay.
            if (load) begin
                shifter <= pending_full ? pending : '0;
                sd      <= pending_full && pending[FW-1];
                ws      <= 1'b0;
                bit_cnt <= '0;
            end else if (frame_end) begin
                ws      <= 1'b1;
                sd      <= 1'b0;
                bit_cnt <= '0;
            end else if (fall_stb) begin
                shifter <= {shifter[FW-2:0], 1'b0};
                sd      <= shifter[FW-2];
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == BW'(SAMPLE_WIDTH - 1)) ws <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: a behavioural I2S receiver rebuilds
// frames from sck/ws/sd and checks them against what the producer handed over.
module tb_i2s_transmitter;
    import i2s_pkg::*;

    localparam int SW        = 32;
    localparam int DIV       = 2;
    localparam int FRAME_CYC = 4 * SW * DIV;

    logic          sys_clk  = 1'b0;
    logic          reset_n  = 1'b0;
    logic          enable   = 1'b0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] left_in  = '0;
    logic [SW-1:0] right_in = '0;
    logic          in_ready, sck_clk, ws, sd, frame_start, underrun;

    int pass_count  = 0;
    int check_count = 0;
    int fs_count    = 0;
    int un_count    = 0;
    int rx_count    = 0;
    int cycle       = 0;

    frame_t sent_q[$];
    frame_t loaded_q[$];

    // receiver model state
    bit            prev_sck  = 1'b0;
    bit            prev_ws   = 1'b1;
    int            last_rise = -1;
    int            low_run   = 0;
    int            n_r       = 0;
    int            ws_low    = 0;
    logic [SW-1:0] rx_l      = '0;
    logic [SW-1:0] rx_r      = '0;
    frame_t        exp_f;

    i2s_transmitter #(.SAMPLE_WIDTH(SW), .SCK_DIV(DIV)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .left_in    (left_in),
        .right_in   (right_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sck_clk    (sck_clk),
        .ws         (ws),
        .sd         (sd),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Offer a frame; with jitter the data changes every cycle until accepted,
    // and only the value present while in_ready is high is expected downstream.
    task automatic apply_stimulus(input frame_t f, input bit jitter);
        int n = 0;
        @(negedge sys_clk);
        {left_in, right_in} = f;
        in_valid = 1'b1;
        while (!in_ready && n < 3 * FRAME_CYC) begin
            @(negedge sys_clk);
            n++;
            if (jitter) {left_in, right_in} = {$urandom(), $urandom()};
        end
        check_output("handshake_accepted", in_ready, 1);
        if (in_ready) sent_q.push_back(frame_t'({left_in, right_in}));
    endtask

    task automatic end_valid();
        @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frame_start();
        int start = fs_count;
        int n = 0;
        while (fs_count == start && n < 3 * FRAME_CYC) begin
            @(negedge sys_clk);
            n++;
        end
        check_output("frame_start_seen", fs_count > start, 1);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 * DIV && n < 3 * FRAME_CYC) begin
            @(negedge sys_clk);
            n++;
            if (ws && !sck_clk && !sd) quiet++;
            else quiet = 0;
        end
        check_output("idle_reached", quiet >= 3 * DIV, 1);
    endtask

    task automatic wait_rises(input int count);
        int seen = 0;
        int n = 0;
        bit last = sck_clk;
        while (seen < count && n < FRAME_CYC) begin
            @(negedge sys_clk);
            n++;
            if (sck_clk && !last) seen++;
            last = sck_clk;
        end
        check_output("sck_rises_seen", seen, count);
    endtask

    // Monitor: tracks loads, rebuilds frames on sck rising edges, compares.
    initial begin
        forever begin
            @(negedge sys_clk);
            cycle++;
            if (!reset_n) begin
                sent_q.delete();
                loaded_q.delete();
                prev_sck  = 1'b0;
                prev_ws   = 1'b1;
                last_rise = -1;
                low_run   = 0;
                n_r       = 0;
                ws_low    = 0;
            end else begin
                if (underrun) check_output("underrun_with_frame_start", frame_start, 1);
                if (frame_start) begin
                    fs_count++;
                    if (underrun) begin
                        un_count++;
                        loaded_q.push_back('0);
                    end else begin
                        check_output("ready_after_load", in_ready, 1);
                        check_output("load_has_sent_frame", sent_q.size() > 0, 1);
                        if (sent_q.size() > 0) loaded_q.push_back(sent_q.pop_front());
                    end
                end

                if (sck_clk) low_run = 0;
                else low_run++;
                if (low_run > 2 * DIV) last_rise = -1;

                if (sck_clk && !prev_sck) begin
                    if (last_rise >= 0) check_output("sck_period", cycle - last_rise, 2 * DIV);
                    last_rise = cycle;
                    if (!ws) begin
                        if (prev_ws) ws_low = 0;
                        rx_l = {rx_l[SW-2:0], sd};
                        ws_low++;
                    end else begin
                        if (!prev_ws) begin
                            check_output("ws_low_periods", ws_low, SW);
                            n_r = 0;
                        end
                        rx_r = {rx_r[SW-2:0], sd};
                        n_r++;
                        if (n_r == SW) begin
                            rx_count++;
                            check_output("rx_frame_expected", loaded_q.size() > 0, 1);
                            if (loaded_q.size() > 0) begin
                                exp_f = loaded_q.pop_front();
                                check_output("rx_frame", {rx_l, rx_r}, exp_f);
                            end
                        end
                    end
                    prev_ws = ws;
                end
                prev_sck = sck_clk;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_count, check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fs0, un0, rx0, last, pulses;
        bit sd_high;
        frame_t f2;

        repeat (3) @(negedge sys_clk);
        check_output("reset_sck", sck_clk, 0);
        check_output("reset_ws", ws, 1);
        check_output("reset_sd", sd, 0);
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_frame_start", frame_start, 0);
        check_output("reset_underrun", underrun, 0);
        @(negedge sys_clk);
        reset_n = 1'b1;

        // Directed frame, single load then drain
        fs0 = fs_count; un0 = un_count; rx0 = rx_count;
        apply_stimulus(frame_t'({32'hA5A5_0F0F, 32'h1234_5678}), 1'b0);
        end_valid();
        enable = 1'b1;
        wait_frame_start();
        enable = 1'b0;
        wait_idle();
        check_output("t1_frame_starts", fs_count - fs0, 1);
        check_output("t1_underruns", un_count - un0, 0);
        check_output("t1_frames_rx", rx_count - rx0, 1);

        // 100 back-to-back random frames with data jitter while pending is full
        un0 = un_count; rx0 = rx_count;
        apply_stimulus(frame_t'({$urandom(), $urandom()}), 1'b1);
        end_valid();
        enable = 1'b1;
        for (int i = 1; i < 100; i++) apply_stimulus(frame_t'({$urandom(), $urandom()}), 1'b1);
        end_valid();
        for (int n = 0; n < 2 * FRAME_CYC && sent_q.size() > 0; n++) @(negedge sys_clk);
        check_output("t2_sent_drained", sent_q.size(), 0);
        enable = 1'b0;
        wait_idle();
        check_output("t2_underruns", un_count - un0, 0);
        check_output("t2_frames_rx", rx_count - rx0, 100);
        check_output("t2_loaded_empty", loaded_q.size(), 0);

        // Streaming with no data: zero frames, underrun every frame period
        fs0 = fs_count; un0 = un_count;
        last = -1; pulses = 0; sd_high = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 4 * FRAME_CYC + FRAME_CYC / 4; c++) begin
            @(negedge sys_clk);
            if (sd) sd_high = 1'b1;
            if (underrun) begin
                if (last >= 0) check_output("underrun_interval", c - last, FRAME_CYC);
                last = c;
                pulses++;
            end
        end
        enable = 1'b0;
        check_output("t3_underrun_pulses", pulses, 5);
        check_output("t3_frame_starts", fs_count - fs0, un_count - un0);
        check_output("t3_sd_high", sd_high, 0);
        wait_idle();

        // Drop enable at bit 10: frame completes, pending frame stays unsent
        rx0 = rx_count;
        apply_stimulus(frame_t'({$urandom(), $urandom()}), 1'b0);
        end_valid();
        enable = 1'b1;
        wait_frame_start();
        f2 = frame_t'({$urandom(), 32'hFFFF_FFFF});
        apply_stimulus(f2, 1'b0);
        end_valid();
        wait_rises(10);
        enable = 1'b0;
        wait_idle();
        fs0 = fs_count;
        repeat (FRAME_CYC + 20) @(negedge sys_clk);
        check_output("t4_no_more_frame_start", fs_count - fs0, 0);
        check_output("t4_frames_rx", rx_count - rx0, 1);
        check_output("t4_pending_kept", in_ready, 0);
        check_output("t4_idle_ws", ws, 1);
        check_output("t4_idle_sck", sck_clk, 0);

        // Async reset during the right slot while sck and sd are high
        enable = 1'b1;
        wait_frame_start();
        for (int n = 0; n < FRAME_CYC && !ws; n++) @(negedge sys_clk);
        for (int n = 0; n < 4 * DIV; n++) begin
            @(posedge sys_clk);
            #2;
            if (sck_clk) break;
        end
        check_output("t5_sck_high_before_reset", sck_clk, 1);
        reset_n = 1'b0;
        #1;
        check_output("t5_async_sck", sck_clk, 0);
        check_output("t5_async_ws", ws, 1);
        check_output("t5_async_sd", sd, 0);
        check_output("t5_async_in_ready", in_ready, 1);
        check_output("t5_async_frame_start", frame_start, 0);
        check_output("t5_async_underrun", underrun, 0);
        enable = 1'b0;
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        rx0 = rx_count;
        un0 = un_count;
        apply_stimulus(frame_t'({32'hFFFF_FFFF, 32'h0000_0001}), 1'b0);
        end_valid();
        enable = 1'b1;
        wait_frame_start();
        enable = 1'b0;
        wait_idle();
        check_output("t5_frames_rx", rx_count - rx0, 1);
        check_output("t5_underruns", un_count - un0, 0);
        check_output("t5_loaded_empty", loaded_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
